// File: rtl/fifo_lane_array_if.sv
// Control and status bundle of the FIFO lane self-test array.
// The master side (board logic or a bench) drives run control and reads
// the per-lane status; the slave side is the lane array itself.
interface fifo_lane_array_if #(
    parameter int L    = 4,
    parameter int A    = 3,
    parameter int ERRW = 16
);
    logic                  en_i;
    logic                  mode_i;
    logic [L-1:0]          rd_pause_i;
    logic [L-1:0]          inject_i;
    logic                  clr_i;
    logic [L-1:0]          fifo_err_o;
    logic [L-1:0]          pg_warn_o;
    logic [L*ERRW-1:0]     err_cnt_o;
    logic [L*(A+1)-1:0]    level_o;

    modport master (
        output en_i, mode_i, rd_pause_i, inject_i, clr_i,
        input  fifo_err_o, pg_warn_o, err_cnt_o, level_o
    );

    modport slave (
        input  en_i, mode_i, rd_pause_i, inject_i, clr_i,
        output fifo_err_o, pg_warn_o, err_cnt_o, level_o
    );
endinterface

// File: rtl/fifo_lane_array.sv
// L-lane FIFO self-test array. Each lane runs a pattern generator into a
// synchronous FIFO and a checker that reads the FIFO back and compares it
// with an identically seeded reference generator. Mismatches and generator
// stalls are reported per lane through sticky flags and saturating counters.
module fifo_lane_array #(
    parameter int             W    = 32,
    parameter int             A    = 3,
    parameter int             L    = 4,
    parameter int             ERRW = 16,
    parameter logic [W-1:0]   TAPS = W'(32'h80200003)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    fifo_lane_array_if.slave bus
);
    localparam int DEPTH = 2**A;

    // Next pattern word: counter or Fibonacci-style LFSR shifting left.
    function automatic logic [W-1:0] gen_next(input logic [W-1:0] s, input logic lfsr);
        if (lfsr) return {s[W-2:0], ^(s & TAPS)};
        return s + W'(1);
    endfunction

    // Run-start seed: counter starts at 0, LFSR at all-ones (never locks up).
    function automatic logic [W-1:0] gen_seed(input logic lfsr);
        return lfsr ? '1 : '0;
    endfunction

    // Mismatch counter increment that sticks at the maximum value.
    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] c);
        return (&c) ? c : c + ERRW'(1);
    endfunction

    logic en_q;
    logic mode_q;
    logic en_rise;
    logic run;

    // The first enabled cycle only flushes and reseeds; traffic starts after it.
    assign en_rise = bus.en_i & ~en_q;
    assign run     = bus.en_i & en_q;

    // Enable edge detect; the pattern mode is sampled only at run start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            en_q <= bus.en_i;
            if (en_rise) mode_q <= bus.mode_i;
        end
    end

    for (genvar i = 0; i < L; i++) begin : g_lane
        logic [W-1:0]    mem [DEPTH];
        logic [A:0]      wr_ptr;
        logic [A:0]      rd_ptr;
        logic [W-1:0]    gen;
        logic [W-1:0]    chk;
        logic            pending;
        logic [W-1:0]    rd_data_p1;
        logic            vld_p1;
        logic [ERRW-1:0] err_cnt;
        logic            fifo_err;
        logic            pg_warn;
        logic            full;
        logic            empty;
        logic            wr;
        logic            rd;
        logic            mismatch;

        // Extra pointer MSB separates full from empty when low bits coincide.
        assign full  = (wr_ptr[A] != rd_ptr[A]) && (wr_ptr[A-1:0] == rd_ptr[A-1:0]);
        assign empty = (wr_ptr == rd_ptr);
        // Write gate uses the pre-read full flag, so full+read only drains.
        assign wr    = run && !full;
        assign rd    = run && !empty && !bus.rd_pause_i[i];
        assign mismatch = run && vld_p1 && (rd_data_p1 != chk);

        // Storage write and registered read port (stage p0 -> p1).
        always_ff @(posedge clk_i) begin
            if (wr) mem[wr_ptr[A-1:0]] <= gen ^ W'(pending);
            if (rd) rd_data_p1 <= mem[rd_ptr[A-1:0]];
        end

        // Pointers, generator, reference and injection bookkeeping.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                gen     <= '0;
                chk     <= '0;
                vld_p1  <= 1'b0;
                pending <= 1'b0;
            end else begin
                if (en_rise) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    gen    <= gen_seed(bus.mode_i);
                    chk    <= gen_seed(bus.mode_i);
                    vld_p1 <= 1'b0;
                end else begin
                    if (wr) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        gen    <= gen_next(gen, mode_q);
                    end
                    if (rd) rd_ptr <= rd_ptr + 1'b1;
                    vld_p1 <= rd;
                    // Reference steps on every compare, never resyncs.
                    if (run && vld_p1) chk <= gen_next(chk, mode_q);
                end
                // At most one injection outstanding; it is consumed by the next write.
                pending <= pending ? !wr : bus.inject_i[i];
            end
        end

        // Sticky status and saturating mismatch count; clear wins over events.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                err_cnt  <= '0;
                fifo_err <= 1'b0;
                pg_warn  <= 1'b0;
            end else if (bus.clr_i) begin
                err_cnt  <= '0;
                fifo_err <= 1'b0;
                pg_warn  <= 1'b0;
            end else begin
                if (mismatch) begin
                    err_cnt  <= sat_inc(err_cnt);
                    fifo_err <= 1'b1;
                end
                if (run && full) pg_warn <= 1'b1;
            end
        end

        assign bus.fifo_err_o[i]                 = fifo_err;
        assign bus.pg_warn_o[i]                  = pg_warn;
        assign bus.err_cnt_o[i*ERRW +: ERRW]     = err_cnt;
        assign bus.level_o[i*(A+1) +: A+1]       = wr_ptr - rd_ptr;
    end
endmodule

// File: tb/tb_fifo_lane_array.sv
// Bench for the FIFO lane self-test array: directed table of scenarios,
// hand sequences for multi-cycle corner cases, and a randomized run checked
// every cycle against a queue-based reference model.
module tb_fifo_lane_array;
    localparam int          W    = 32;
    localparam int          A    = 3;
    localparam int          L    = 4;
    localparam int          ERRW = 4;
    localparam logic [31:0] TAPS = 32'h80200003;

    logic clk;
    logic rst_n;

    fifo_lane_array_if #(.L(L), .A(A), .ERRW(ERRW)) bus ();

    fifo_lane_array #(.W(W), .A(A), .L(L), .ERRW(ERRW), .TAPS(TAPS)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_q [L][$];
    logic [31:0] m_gen   [L];
    logic [31:0] m_ref   [L];
    logic [31:0] m_iword [L];
    logic        m_pend  [L];
    logic        m_ivld  [L];
    logic        m_ferr  [L];
    logic        m_warn  [L];
    int          m_err   [L];
    logic        m_en_prev;
    logic        m_mode;

    function automatic logic [31:0] pat_seed(input logic m);
        return m ? 32'hFFFF_FFFF : 32'h0;
    endfunction

    function automatic logic [31:0] pat_next(input logic [31:0] s, input logic m);
        if (!m) return s + 32'd1;
        return (s << 1) | 32'($countones(s & TAPS) % 2);
    endfunction

    task automatic model_reset();
        m_en_prev = 1'b0;
        m_mode    = 1'b0;
        for (int i = 0; i < L; i++) begin
            m_q[i].delete();
            m_gen[i] = '0; m_ref[i] = '0; m_iword[i] = '0;
            m_pend[i] = 1'b0; m_ivld[i] = 1'b0;
            m_ferr[i] = 1'b0; m_warn[i] = 1'b0; m_err[i] = 0;
        end
    endtask

    task automatic model_step();
        logic rise, run, full, empty, rd, wr;
        rise = bus.en_i && !m_en_prev;
        run  = bus.en_i && m_en_prev;
        for (int i = 0; i < L; i++) begin
            full  = (m_q[i].size() == 2**A);
            empty = (m_q[i].size() == 0);
            if (bus.clr_i) begin
                m_err[i] = 0; m_ferr[i] = 1'b0; m_warn[i] = 1'b0;
            end else begin
                if (run && m_ivld[i] && (m_iword[i] != m_ref[i])) begin
                    if (m_err[i] < 2**ERRW - 1) m_err[i]++;
                    m_ferr[i] = 1'b1;
                end
                if (run && full) m_warn[i] = 1'b1;
            end
            if (run && m_ivld[i]) m_ref[i] = pat_next(m_ref[i], m_mode);
            wr = 1'b0;
            if (rise) begin
                m_q[i].delete();
                m_gen[i]  = pat_seed(bus.mode_i);
                m_ref[i]  = pat_seed(bus.mode_i);
                m_ivld[i] = 1'b0;
            end else begin
                rd = run && !empty && !bus.rd_pause_i[i];
                wr = run && !full;
                if (rd) m_iword[i] = m_q[i].pop_front();
                if (wr) begin
                    m_q[i].push_back(m_gen[i] ^ 32'(m_pend[i]));
                    m_gen[i] = pat_next(m_gen[i], m_mode);
                end
                m_ivld[i] = rd;
            end
            m_pend[i] = m_pend[i] ? !wr : bus.inject_i[i];
        end
        if (rise) m_mode = bus.mode_i;
        m_en_prev = bus.en_i;
    endtask

    function automatic logic [63:0] exp_status();
        logic [L-1:0]       fe, pw;
        logic [L*ERRW-1:0]  ec;
        logic [L*(A+1)-1:0] lv;
        for (int i = 0; i < L; i++) begin
            fe[i] = m_ferr[i];
            pw[i] = m_warn[i];
            ec[i*ERRW +: ERRW]   = ERRW'(m_err[i]);
            lv[i*(A+1) +: A+1]   = (A+1)'(m_q[i].size());
        end
        return 64'({fe, pw, ec, lv});
    endfunction

    function automatic logic [63:0] act_status();
        return 64'({bus.fifo_err_o, bus.pg_warn_o, bus.err_cnt_o, bus.level_o});
    endfunction

    // One clock: advance model with current inputs, then compare after the edge.
    task automatic cycle();
        logic        v0, v1;
        logic [31:0] d0, d1;
        model_step();
        @(posedge clk);
        #1;
        chk("status", act_status(), exp_status());
        v0 = dut.g_lane[0].vld_p1; d0 = dut.g_lane[0].rd_data_p1;
        v1 = dut.g_lane[1].vld_p1; d1 = dut.g_lane[1].rd_data_p1;
        chk("data_lane0", 64'({v0, m_ivld[0] ? d0 : 32'h0}),
            64'({m_ivld[0], m_ivld[0] ? m_iword[0] : 32'h0}));
        chk("data_lane1", 64'({v1, m_ivld[1] ? d1 : 32'h0}),
            64'({m_ivld[1], m_ivld[1] ? m_iword[1] : 32'h0}));
    endtask

    // Expects the next cycle to be an enable rising edge.
    task automatic first_words(input logic m, input logic [31:0] e0, input logic [31:0] e1);
        bus.en_i = 1'b1; bus.mode_i = m;
        bus.rd_pause_i = '0; bus.inject_i = '0; bus.clr_i = 1'b0;
        repeat (3) cycle();
        chk("first_word0", 64'({dut.g_lane[0].vld_p1, dut.g_lane[0].rd_data_p1}), 64'({1'b1, e0}));
        cycle();
        chk("first_word1", 64'({dut.g_lane[0].vld_p1, dut.g_lane[0].rd_data_p1}), 64'({1'b1, e1}));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        en;
        logic        mode;
        logic [3:0]  pause;
        logic [3:0]  inject;
        logic        clr;
        int          cycles;
        logic [3:0]  e_ferr;
        logic [3:0]  e_warn;
        logic [15:0] e_cnt;
        logic [15:0] e_lvl;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int k);
        for (int c = 0; c < vecs[k].cycles; c++) begin
            bus.en_i       = vecs[k].en;
            bus.mode_i     = vecs[k].mode;
            bus.rd_pause_i = vecs[k].pause;
            bus.inject_i   = (c == 0) ? vecs[k].inject : 4'b0000;
            bus.clr_i      = (c == 0) ? vecs[k].clr : 1'b0;
            cycle();
        end
        chk($sformatf("vec%0d", k), act_status(),
            64'({vecs[k].e_ferr, vecs[k].e_warn, vecs[k].e_cnt, vecs[k].e_lvl}));
    endtask

    initial begin
        //            en    mode  pause    inject   clr   cyc   ferr     warn     cnt       level
        vecs[0] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 200,  4'b0000, 4'b0000, 16'h0000, 16'h1111};
        vecs[1] = '{1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 20,   4'b0000, 4'b0010, 16'h0000, 16'h1181};
        vecs[2] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 20,   4'b0000, 4'b0010, 16'h0000, 16'h1171};
        vecs[3] = '{1'b1, 1'b0, 4'b0000, 4'b0100, 1'b0, 10,   4'b0100, 4'b0010, 16'h0100, 16'h1171};
        vecs[4] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 5,    4'b0000, 4'b0000, 16'h0000, 16'h1171};
        vecs[5] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 5,    4'b0000, 4'b0000, 16'h0000, 16'h1171};
        vecs[6] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1000, 4'b0000, 4'b0000, 16'h0000, 16'h1111};

        rst_n = 1'b0;
        bus.en_i = 1'b0; bus.mode_i = 1'b0;
        bus.rd_pause_i = '0; bus.inject_i = '0; bus.clr_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("reset", act_status(), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();

        // Counter mode start, then pause/full, injection, clear, disable.
        first_words(1'b0, 32'h0000_0000, 32'h0000_0001);
        for (int k = 0; k <= 5; k++) run_vec(k);

        // LFSR run; mode changes while running must be ignored.
        first_words(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_vec(6);

        // Saturation of the lane-0 counter, hold, then clear.
        for (int n = 0; n < 20; n++) begin
            bus.inject_i = 4'b0001; cycle();
            bus.inject_i = 4'b0000; repeat (3) cycle();
        end
        chk("sat_cnt", 64'(bus.err_cnt_o[3:0]), 64'h0F);
        chk("sat_flag", 64'(bus.fifo_err_o), 64'h1);
        repeat (4) cycle();
        chk("sat_hold", 64'(bus.err_cnt_o[3:0]), 64'h0F);
        bus.clr_i = 1'b1; cycle(); bus.clr_i = 1'b0;
        chk("clr_cnt", 64'(bus.err_cnt_o), 64'h0);
        chk("clr_flags", 64'({bus.fifo_err_o, bus.pg_warn_o}), 64'h0);

        // Clear coinciding with the mismatch compare suppresses the count.
        bus.inject_i = 4'b1000; cycle();
        bus.inject_i = 4'b0000; cycle(); cycle();
        bus.clr_i = 1'b1; cycle(); bus.clr_i = 1'b0;
        chk("clr_prio", 64'({bus.fifo_err_o[3], bus.err_cnt_o[15:12]}), 64'h0);
        cycle();
        chk("clr_prio_after", 64'({bus.fifo_err_o[3], bus.err_cnt_o[15:12]}), 64'h0);

        // Async reset while lane 3 is full, then restart with en held high.
        bus.rd_pause_i = 4'b1000;
        repeat (12) cycle();
        chk("lane3_full", 64'(bus.level_o[15:12]), 64'd8);
        rst_n = 1'b0;
        #2;
        chk("async_rst", act_status(), 64'h0);
        bus.rd_pause_i = '0;
        model_reset();
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        first_words(1'b0, 32'h0000_0000, 32'h0000_0001);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) bus.rd_pause_i = 4'($urandom_range(0, 15));
            bus.inject_i = 4'($urandom) & 4'($urandom) & 4'($urandom);
            bus.clr_i    = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) bus.en_i = !bus.en_i;
            bus.mode_i   = 1'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
